npu_scheduler: RTL

NPU_SCHEDULER -- requirements
Module: npu_scheduler

---
 rtl/npu_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/npu_scheduler.sv
// Instruction scheduler: FIFO-buffered 128-bit instructions issued one at a time to the NPU.
// Optional watchdog in WAIT enabled by defining NPU_SCHED_TIMEOUT_EN (adds the o_timeout port).
module npu_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] inst_in,
  input  logic         inst_valid,
  output logic         o_inst_ready,
  output logic [127:0] o_cur_inst,
  output logic         o_start_calculate,
  input  logic         i_calculate_end,
  output logic         o_busy,
  output logic         o_all_done,
  output logic [15:0]  o_done_cnt
`ifdef NPU_SCHED_TIMEOUT_EN
  ,
  output logic         o_timeout
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("npu_scheduler: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t       state;
  logic [127:0] mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic [127:0] cur_inst;
  logic         start_calc;
  logic [15:0]  done_cnt;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign push       = inst_valid && o_inst_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;

  // Gated by rst so the host sees no ready/done indication while reset is held.
  assign o_inst_ready      = rst && !fifo_full;
  assign o_all_done        = rst && (state == S_IDLE) && fifo_empty;
  assign o_busy            = (state != S_IDLE);
  assign o_cur_inst        = cur_inst;
  assign o_start_calculate = start_calc;
  assign o_done_cnt        = done_cnt;

  // NOTE: storage array has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= inst_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

`ifdef NPU_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
  logic        timeout;
  assign o_timeout = timeout;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cur_inst   <= '0;
      start_calc <= 1'b0;
      done_cnt   <= '0;
`ifdef NPU_SCHED_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      start_calc <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_inst <= mem[rd_ptr[AW-1:0]];
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Registered here so the pulse is high for exactly the START cycle.
          start_calc <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
`ifdef NPU_SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_calculate_end) begin
            state <= S_DONE;
`ifdef NPU_SCHED_TIMEOUT_EN
          end else if (wd_cnt == WD_LAST) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
`endif
          end
        end
        S_DONE: begin
          done_cnt <= done_cnt + 16'd1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
